// File: rtl/data_mem_master_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : data_mem_master_pkg
// Description : Shared widths, depth and controller state encoding for the
//               data-memory access path.
// Revision    : 1.0 - initial release
// ============================================================================
package data_mem_master_pkg;

    localparam int DATA_W_DEFAULT    = 16;
    localparam int ADDR_W_DEFAULT    = 16;
    localparam int MEM_DEPTH_DEFAULT = 1600;

    localparam logic [2:0] C_ST_IDLE     = 3'd0;
    localparam logic [2:0] C_ST_RD_ISSUE = 3'd1;
    localparam logic [2:0] C_ST_RD_WAIT  = 3'd2;
    localparam logic [2:0] C_ST_WRITE    = 3'd3;
    localparam logic [2:0] C_ST_RESP     = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE     = C_ST_IDLE,
        ST_RD_ISSUE = C_ST_RD_ISSUE,
        ST_RD_WAIT  = C_ST_RD_WAIT,
        ST_WRITE    = C_ST_WRITE,
        ST_RESP     = C_ST_RESP
    } state_t;

endpackage : data_mem_master_pkg
`default_nettype wire

// File: rtl/data_mem_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : data_mem_master
// Description : Single-request load/store controller for the 16-bit data
//               memory; sequences read/write strobes and returns responses.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_master
    import data_mem_master_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEFAULT,
    parameter int ADDR_W    = ADDR_W_DEFAULT,
    parameter int MEM_DEPTH = MEM_DEPTH_DEFAULT
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_error,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    localparam logic [ADDR_W-1:0] C_DEPTH = ADDR_W'(MEM_DEPTH);

    state_t            r_state,        w_state_nxt;
    logic              r_req_ready,    w_req_ready_nxt;
    logic              r_rsp_valid,    w_rsp_valid_nxt;
    logic              r_rsp_error,    w_rsp_error_nxt;
    logic [DATA_W-1:0] r_rsp_rdata,    w_rsp_rdata_nxt;
    logic              r_mem_read,     w_mem_read_nxt;
    logic              r_mem_write,    w_mem_write_nxt;
    logic [ADDR_W-1:0] r_mem_address,  w_mem_address_nxt;
    logic [DATA_W-1:0] r_mem_wdata,    w_mem_wdata_nxt;
    logic              w_err;
    logic              w_accept;

    assign w_err    = (req_addr >= C_DEPTH);
    assign w_accept = req_valid && r_req_ready;

    // Every output is a register so reset clears them all asynchronously.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_req_ready   <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_error   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_address <= '0;
            r_mem_wdata   <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_req_ready   <= w_req_ready_nxt;
            r_rsp_valid   <= w_rsp_valid_nxt;
            r_rsp_error   <= w_rsp_error_nxt;
            r_rsp_rdata   <= w_rsp_rdata_nxt;
            r_mem_read    <= w_mem_read_nxt;
            r_mem_write   <= w_mem_write_nxt;
            r_mem_address <= w_mem_address_nxt;
            r_mem_wdata   <= w_mem_wdata_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_rsp_valid_nxt   = r_rsp_valid;
        w_rsp_error_nxt   = r_rsp_error;
        w_rsp_rdata_nxt   = r_rsp_rdata;
        w_mem_read_nxt    = 1'b0;
        w_mem_write_nxt   = 1'b0;
        w_mem_address_nxt = r_mem_address;
        w_mem_wdata_nxt   = r_mem_wdata;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_mem_address_nxt = req_addr;
                    w_mem_wdata_nxt   = req_wdata;
                    w_rsp_error_nxt   = w_err;
                    w_rsp_rdata_nxt   = '0;
                    if (w_err) begin
                        w_rsp_valid_nxt = 1'b1;
                        w_state_nxt     = ST_RESP;
                    end else if (req_write) begin
                        w_mem_write_nxt = 1'b1;
                        w_state_nxt     = ST_WRITE;
                    end else begin
                        w_mem_read_nxt  = 1'b1;
                        w_state_nxt     = ST_RD_ISSUE;
                    end
                end
            end
            ST_RD_ISSUE: begin
                w_state_nxt = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                // Memory presents the word sampled on the previous edge.
                w_rsp_rdata_nxt = mem_read_data;
                w_rsp_valid_nxt = 1'b1;
                w_state_nxt     = ST_RESP;
            end
            ST_WRITE: begin
                w_rsp_valid_nxt = 1'b1;
                w_state_nxt     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_state_nxt     = ST_IDLE;
                end
            end
            default: begin
                w_rsp_valid_nxt = 1'b0;
                w_state_nxt     = ST_IDLE;
            end
        endcase

        // Ready only once IDLE has been reached, never on the return edge itself.
        w_req_ready_nxt = (w_state_nxt == ST_IDLE);
    end

    assign req_ready      = r_req_ready;
    assign rsp_valid      = r_rsp_valid;
    assign rsp_error      = r_rsp_error;
    assign rsp_rdata      = r_rsp_rdata;
    assign mem_read       = r_mem_read;
    assign mem_write      = r_mem_write;
    assign mem_address    = r_mem_address;
    assign mem_write_data = r_mem_wdata;

endmodule : data_mem_master
`default_nettype wire

// File: tb/tb_data_mem_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_master
// Description : Self-checking bench for data_mem_master with a data-memory
//               model and a transaction-level reference memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_master;
    import data_mem_master_pkg::*;

    localparam int DW    = DATA_W_DEFAULT;
    localparam int AW    = ADDR_W_DEFAULT;
    localparam int DEPTH = MEM_DEPTH_DEFAULT;

    logic          clock;
    logic          reset_n;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_ready, rsp_error;
    logic [DW-1:0] rsp_rdata;
    logic          mem_read, mem_write;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_write_data, mem_read_data;

    data_mem_master u_dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_rdata      (rsp_rdata),
        .rsp_error      (rsp_error),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [DW-1:0] init_val(input int a);
        return DW'((a * 40503) ^ 23130);
    endfunction

    // Data memory: read sampled on the rising edge, write committed on the falling edge.
    logic [DW-1:0] mem     [0:DEPTH-1];
    logic          written [0:DEPTH-1];
    initial mem_read_data = '0;
    always @(posedge clock)
        if (mem_read && int'(mem_address) < DEPTH)
            mem_read_data <= written[mem_address] ? mem[mem_address] : init_val(int'(mem_address));
    always @(negedge clock)
        if (mem_write && int'(mem_address) < DEPTH) begin
            mem[mem_address]     <= mem_write_data;
            written[mem_address] <= 1'b1;
        end

    // Reference memory, updated only when a store is known to have landed.
    logic [DW-1:0] ref_mem [0:DEPTH-1];

    int n_assert = 0;
    int n_fail   = 0;
    int next_e   = 0;
    bit space_chk = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_error"}, rsp_error, 0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 0);
        check({tag, "_strobes"},   {mem_read, mem_write}, 0);
        check({tag, "_mem_addr"},  mem_address, 0);
        check({tag, "_mem_wdata"}, mem_write_data, 0);
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        check("ready_during_release", req_ready, 0);
        @(posedge clock); #1;
        check("ready_after_release", req_ready, 1);
        check("rsp_valid_after_release", rsp_valid, 0);
    endtask

    // Wait for req_ready, present the request and hand-shake at edge E.
    task automatic handshake(input logic wr, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wd, output int e);
        int n;
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin @(posedge clock); #1; n++; end
        check("req_ready_timeout", (n < 20), 1);
        @(posedge clock); #1;
        e = cyc;
    endtask

    // Full transaction: timing, strobes, response contents and backpressure.
    task automatic xact(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        input int hold, input bit chain);
        int e, lat, rdc, wrc, exp_lat;
        logic err;
        logic [DW-1:0] exp_rd;
        err     = (int'(addr) >= DEPTH);
        exp_rd  = (wr || err) ? '0 : ref_mem[addr];
        exp_lat = err ? 0 : (wr ? 1 : 2);
        handshake(wr, addr, wd, e);
        if (space_chk) check("spacing", e, next_e);
        if (!chain) req_valid = 1'b0;
        lat = 0; rdc = 0; wrc = 0;
        while (rsp_valid !== 1'b1 && lat < 10) begin
            check("no_overlap", mem_read & mem_write, 0);
            if (mem_read)  begin rdc++; check("rd_addr", mem_address, addr); end
            if (mem_write) begin
                wrc++;
                check("wr_addr", mem_address, addr);
                check("wr_data", mem_write_data, wd);
            end
            @(posedge clock); #1; lat++;
        end
        check("rsp_latency", lat, exp_lat);
        check("rd_strobes", rdc, (!wr && !err) ? 1 : 0);
        check("wr_strobes", wrc, (wr && !err) ? 1 : 0);
        check("rsp_error", rsp_error, err);
        check("rsp_rdata", rsp_rdata, exp_rd);
        check("req_ready_in_resp", req_ready, 0);
        if (wr && !err) ref_mem[addr] = wd;
        if (hold > 0) begin
            rsp_ready = 1'b0;
            repeat (hold) begin
                @(posedge clock); #1;
                check("bp_rsp_valid", rsp_valid, 1);
                check("bp_rsp_rdata", rsp_rdata, exp_rd);
                check("bp_rsp_error", rsp_error, err);
                check("bp_req_ready", req_ready, 0);
                check("bp_strobes", {mem_read, mem_write}, 0);
            end
            rsp_ready = 1'b1;
        end
        @(posedge clock); #1;
        check("rsp_valid_drop", rsp_valid, 0);
        check("ready_after_resp", req_ready, 1);
        next_e = e + exp_lat + 2 + hold;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] old_v, new_v;
        int e;

        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b1;
        reset_n   = 1'b1;
        #1 reset_n = 1'b0;
        #2 check_all_zero("reset");
        release_reset();

        // Store then load
        xact(1'b1, 16'd10, 16'h00A5, 0, 1'b0);
        xact(1'b0, 16'd10, '0, 0, 1'b0);

        // Boundary addresses
        xact(1'b1, 16'd1599, 16'hBEEF, 0, 1'b0);
        xact(1'b0, 16'd1599, '0, 0, 1'b0);
        xact(1'b0, 16'd1600, '0, 0, 1'b0);
        xact(1'b1, 16'hFFFF, 16'h1234, 0, 1'b0);

        // Backpressure, then the next request one cycle after the handshake
        xact(1'b0, 16'd10, '0, 5, 1'b1);
        space_chk = 1'b1;
        xact(1'b0, 16'd1599, '0, 0, 1'b0);

        // Back-to-back alternating stores/loads with req_valid held high
        for (int i = 0; i < 8; i++) begin
            xact(1'b1, AW'(i), DW'($urandom), 0, 1'b1);
            xact(1'b0, AW'(i), '0, 0, 1'b1);
        end

        // Randomized mix including errors and backpressure
        for (int i = 0; i < 40; i++) begin
            int sel;
            logic [AW-1:0] a;
            sel = $urandom_range(0, 9);
            if (sel == 0)      a = AW'($urandom_range(DEPTH, 65535));
            else if (sel == 1) a = AW'(DEPTH - 1);
            else               a = AW'($urandom_range(0, 15));
            xact(1'($urandom_range(0, 1)), a, DW'($urandom), $urandom_range(0, 2), 1'b1);
        end
        req_valid = 1'b0;
        space_chk = 1'b0;

        // Reset during RD_WAIT
        handshake(1'b0, 16'd5, '0, e);
        req_valid = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b0;
        #1 check_all_zero("rst_load");
        release_reset();
        xact(1'b0, 16'd5, '0, 0, 1'b0);

        // Reset in the first half of WRITE: store must not land
        old_v = ref_mem[20];
        new_v = ~old_v;
        handshake(1'b1, 16'd20, new_v, e);
        req_valid = 1'b0;
        reset_n = 1'b0;
        #1 check("rst_store_early_strobe", mem_write, 0);
        release_reset();
        xact(1'b0, 16'd20, '0, 0, 1'b0);

        // Reset in the second half of WRITE: store has landed
        new_v = ~ref_mem[21];
        handshake(1'b1, 16'd21, new_v, e);
        req_valid = 1'b0;
        #5 reset_n = 1'b0;
        #1 check("rst_store_late_strobe", mem_write, 0);
        ref_mem[21] = new_v;
        release_reset();
        xact(1'b0, 16'd21, '0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_data_mem_master
`default_nettype wire

// File: doc/data_mem_master.md
# data_mem_master

Initiator-side access controller for the processor's 16-bit data memory. Accepts single load/store requests from the pipeline over a valid/ready handshake and sequences the memory strobes to match the memory's timing: read sampled on the rising edge, write committed on the falling edge. Returns read data or a write acknowledge on a response channel with backpressure. Flags out-of-range addresses without touching memory.

## Interface
- DATA_W, 16, data word width
- ADDR_W, 16, address width
- MEM_DEPTH, 1600, number of valid words; legal addresses are 0..MEM_DEPTH-1

Ports:
- clock  in  1  system clock; all state changes on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_write  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  store data
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes the response
- rsp_rdata  out  DATA_W  load data; 0 for stores and errors
- rsp_error  out  1  address out of range
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_address  out  ADDR_W  memory address
- mem_write_data  out  DATA_W  memory write data
- mem_read_data  in  DATA_W  memory read data

## Operation
- States: IDLE, RD_ISSUE, RD_WAIT, WRITE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch addr, wdata and write.
  - Evaluate err = (req_addr >= MEM_DEPTH), an unsigned compare at ADDR_W bits.
  - If err -> RESP with rsp_error=1. Else if write -> WRITE. Else -> RD_ISSUE.
- RD_ISSUE: mem_read=1 for exactly one cycle -> RD_WAIT.
- RD_WAIT:
  - mem_read=0.
  - Capture mem_read_data into rsp_rdata at the closing edge -> RESP.
- WRITE: mem_write=1 for exactly one cycle; the memory commits on that cycle's falling edge -> RESP.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_error are held stable.
  - On rsp_ready -> IDLE and clear rsp_valid.
  - No new request is accepted in the same cycle.
- req_ready=0 in every state except IDLE.
- mem_address and mem_write_data come from the latched request and are stable for the whole access.
- mem_read and mem_write are never both 1.
- Neither strobe is ever asserted for an erroring request.

## Timing
- Reset (reset_n low) forces asynchronously:
  - state=IDLE
  - rsp_valid=0, rsp_error=0, rsp_rdata=0
  - mem_read=0, mem_write=0, mem_address=0, mem_write_data=0
  - req_ready=0
- After reset_n rises, req_ready=1 from the next cycle.
- Take edge E as the edge where req_valid and req_ready are both 1.
- Load: mem_read is high in cycle E..E+1. The memory samples at E+1. rsp_valid rises after E+2.
- Store: mem_write is high in cycle E..E+1. rsp_valid rises after E+1.
- Error: rsp_valid rises after E.
- Throughput limits:
  - Minimum request spacing with rsp_ready held at 1: load 4 cycles, store 3, error 2.
  - The one cycle of IDLE between accesses is mandatory.
- Backpressure: rsp_ready low holds RESP indefinitely with all response outputs stable.
- Reset mid-operation:
  - Aborts immediately; strobes drop asynchronously.
  - A store reset during WRITE before the falling edge is not performed. One reset after the falling edge is performed.
  - A pending response is discarded.
- Boundary addresses: address MEM_DEPTH-1 is legal; MEM_DEPTH and 0xFFFF return an error.

## Structure
- The shared package holds:
  - the state encoding (3-bit localparams)
  - MEM_DEPTH_DEFAULT = 1600
  - DATA_W and ADDR_W defaults, shared with the data memory
- Single module; no sub-module.
- The range check is a one-line compare inline.
- The bench instantiates this block against the existing data memory.

## Test plan
- Store then load:
  - Store 0x00A5 to addr 10 -> mem_write is high 1 cycle with address 10; rsp_valid after E+1 with rsp_error=0.
  - Load addr 10 -> rsp_rdata=0x00A5 after E+2.
- Boundary:
  - Store 0xBEEF to addr 1599 then load it -> 0xBEEF.
  - Load addr 1600 -> rsp_error=1, rsp_rdata=0, mem_read never asserted.
  - Store addr 0xFFFF -> rsp_error=1, mem_write never asserted.
- Backpressure: load with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata held constant, req_ready=0, no strobes; request accepted 1 cycle after the handshake.
- Back-to-back: 8 alternating stores/loads to addrs 0..7 with req_valid held high and rsp_ready=1 -> every load returns its stored value, strobes never overlap, spacing is 3/4 cycles.
- Reset mid-load: assert reset_n=0 in RD_WAIT -> all outputs 0 asynchronously, no rsp_valid; the next load after release completes normally.
- Reset mid-store: assert reset_n=0 in the first half of the WRITE cycle -> a later load of that address returns the old value.
